fir_feeder: RTL and testbench

Single-clock front end that drives the shared serial load port of the 64-tap FIR datapath. Collects a complete 65-word coefficient set from the host into a local buffer and forwards the audio sample stream one word per strobe. Commits the finished set to the filter as one uninterrupted 65-word shift burst, so the filter never computes with a partially loaded set. It drives the filter's single data bus, which is shared between coefficient shifts and sample shifts; the filter-side clock enables come from this block.

---
 rtl/fir_feeder_if.sv | 28 ++
 rtl/fir_feeder.sv | 93 +++++++++
 tb/tb_fir_feeder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_feeder_if.sv
// Handshake bundle of the FIR feeder: host coefficient/sample streams and the
// shared serial load bus toward the filter.
interface fir_feeder_if #(parameter int W = 32);
  logic [W-1:0] coeff_data;
  logic         coeff_valid;
  logic         coeff_ready;
  logic         coeff_restart;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         sample_ready;
  logic [W-1:0] fir_in;
  logic         fir_coeff_en;
  logic         fir_sample_en;
  logic         busy;
  logic [6:0]   coeff_cnt;

  modport slave (
    input  coeff_data, coeff_valid, coeff_restart, sample_data, sample_valid,
    output coeff_ready, sample_ready, fir_in, fir_coeff_en, fir_sample_en,
           busy, coeff_cnt
  );

  modport master (
    output coeff_data, coeff_valid, coeff_restart, sample_data, sample_valid,
    input  coeff_ready, sample_ready, fir_in, fir_coeff_en, fir_sample_en,
           busy, coeff_cnt
  );
endinterface

// File: rtl/fir_feeder.sv
// Buffers a full TAPS+1 word coefficient set, then commits it to the filter as
// one unbroken shift burst; samples share the same registered filter bus.
module fir_feeder #(
  parameter int TAPS = 64,
  parameter int W    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  fir_feeder_if.slave bus
);
  localparam logic [6:0] LAST = 7'(TAPS);
  localparam logic [6:0] DONE = 7'(TAPS + 1);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_e;

  state_e       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [6:0]   rd_q, rd_d;
  logic [W-1:0] fir_in_q, fir_in_d;
  logic         cen_q, cen_d;
  logic         sen_q, sen_d;
  logic [W-1:0] buf_q [TAPS+1];

  logic idle, coeff_go, sample_go, restart, wr_en, last_wr, emit;

  assign idle      = (state_q == IDLE);
  assign coeff_go  = bus.coeff_valid & bus.coeff_ready;
  assign sample_go = bus.sample_valid & bus.sample_ready;
  assign restart   = idle & bus.coeff_restart;
  assign wr_en     = coeff_go & ~restart;
  assign last_wr   = wr_en & (cnt_q == LAST);
  assign emit      = (state_q == PEND) | ((state_q == FLUSH) & (rd_q != DONE));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      fir_in_q <= '0;
      cen_q    <= 1'b0;
      sen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      fir_in_q <= fir_in_d;
      cen_q    <= cen_d;
      sen_q    <= sen_d;
    end
  end

  // No reset on the set buffer: a reset just orphans whatever was collected.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[cnt_q] <= bus.coeff_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (last_wr) state_d = PEND;
      PEND:    state_d = FLUSH;
      FLUSH:   if (rd_q == DONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    rd_d     = '0;
    fir_in_d = fir_in_q;
    cen_d    = 1'b0;
    sen_d    = 1'b0;
    if (restart || last_wr) cnt_d = '0;
    else if (wr_en)         cnt_d = cnt_q + 7'd1;
    // PEND already fetches word 0, so the bus register shows it on FLUSH entry.
    if (emit) begin
      fir_in_d = buf_q[rd_q];
      cen_d    = 1'b1;
      rd_d     = rd_q + 7'd1;
    end else if (sample_go) begin
      fir_in_d = bus.sample_data;
      sen_d    = 1'b1;
    end
  end

  assign bus.coeff_ready   = reset_n & idle;
  assign bus.sample_ready  = reset_n & idle;
  assign bus.busy          = ~idle;
  assign bus.coeff_cnt     = cnt_q;
  assign bus.fir_in        = fir_in_q;
  assign bus.fir_coeff_en  = cen_q;
  assign bus.fir_sample_en = sen_q;
endmodule

// File: tb/tb_fir_feeder.sv
// Bench for fir_feeder: a table of sample vectors, directed multi-cycle
// sequences, and random traffic checked by an event-scheduling reference model.
module tb_fir_feeder;
  localparam int TAPS = 64;
  localparam int W    = 32;
  localparam int NSET = TAPS + 1;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_bad = 0;

  fir_feeder_if #(.W(W)) bus ();

  fir_feeder #(.TAPS(TAPS), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Works from the stated timing rules: each accepted word/sample schedules a
  // bus event at an absolute future cycle; readies are low until a set's
  // commit window has elapsed.
  int          t        = 0;
  bit          armed    = 1'b0;
  int          m_cnt    = 0;
  int          rdy_from = 0;
  logic [W-1:0] m_fin   = '0;
  logic [W-1:0] m_set [NSET];
  int          ev_kind [int];
  logic [W-1:0] ev_dat [int];

  always @(negedge clk) begin
    bit e_cen, e_sen, e_busy, e_rdy;
    t++;
    if (armed) begin
      e_cen = 1'b0;
      e_sen = 1'b0;
      if (ev_kind.exists(t)) begin
        e_cen = (ev_kind[t] == 1);
        e_sen = (ev_kind[t] == 2);
        m_fin = ev_dat[t];
        ev_kind.delete(t);
        ev_dat.delete(t);
      end
      e_busy = (t < rdy_from);
      e_rdy  = reset_n && !e_busy;
      chk("m_coeff_ready", bus.coeff_ready, e_rdy);
      chk("m_sample_ready", bus.sample_ready, e_rdy);
      chk("m_busy", bus.busy, e_busy);
      chk("m_coeff_cnt", bus.coeff_cnt, m_cnt);
      chk("m_coeff_en", bus.fir_coeff_en, e_cen);
      chk("m_sample_en", bus.fir_sample_en, e_sen);
      chk("m_fir_in", bus.fir_in, m_fin);
      chk("m_en_exclusive", bus.fir_coeff_en & bus.fir_sample_en, 0);
      if (e_rdy) begin
        if (bus.coeff_restart) m_cnt = 0;
        else if (bus.coeff_valid) begin
          m_set[m_cnt] = bus.coeff_data;
          m_cnt++;
          if (m_cnt == NSET) begin
            for (int k = 0; k < NSET; k++) begin
              ev_kind[t + 2 + k] = 1;
              ev_dat[t + 2 + k]  = m_set[k];
            end
            rdy_from = t + NSET + 2;
            m_cnt    = 0;
          end
        end
        if (bus.sample_valid) begin
          ev_kind[t + 1] = 2;
          ev_dat[t + 1]  = bus.sample_data;
        end
      end
    end
    if (!reset_n) begin
      armed = 1'b1;
      ev_kind.delete();
      ev_dat.delete();
      m_fin    = '0;
      m_cnt    = 0;
      rdy_from = t + 1;
    end
  end

  // ---------------- directed sequences ----------------
  task automatic load_set(input logic [W-1:0] base, input bit collide, input bit rst30);
    for (int i = 0; i < NSET; i++) begin
      bus.coeff_valid = 1'b1;
      bus.coeff_data  = base + W'(i);
      if (collide && i == TAPS) begin
        bus.sample_valid = 1'b1;
        bus.sample_data  = 32'h1234;
      end
      if (i == TAPS) begin
        at_neg();
        chk("cnt_at_scale_word", bus.coeff_cnt, TAPS);
      end
      tick();
    end
    bus.coeff_valid = 1'b0;
    if (collide) bus.sample_data = 32'h5678;
    at_neg();  // t+1
    chk("pend_ready", bus.coeff_ready, 0);
    chk("pend_busy", bus.busy, 1);
    chk("pend_coeff_en", bus.fir_coeff_en, 0);
    if (collide) begin
      chk("collide_sample_en", bus.fir_sample_en, 1);
      chk("collide_sample", bus.fir_in, 32'h1234);
    end
    tick();
    for (int k = 0; k < NSET; k++) begin  // t+2+k
      if (rst30 && k == 30) reset_n = 1'b0;
      at_neg();
      chk("burst_en", bus.fir_coeff_en, 1);
      chk("burst_word", bus.fir_in, base + W'(k));
      chk("burst_ready", bus.sample_ready, 0);
      if (collide) chk("burst_no_sample", bus.fir_sample_en, 0);
      tick();
      if (rst30 && k == 30) begin
        at_neg();
        chk("rst_coeff_en", bus.fir_coeff_en, 0);
        chk("rst_sample_en", bus.fir_sample_en, 0);
        chk("rst_cnt", bus.coeff_cnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready_low", bus.coeff_ready, 0);
        tick();
        reset_n = 1'b1;
        at_neg();
        chk("rst_ready_back", bus.coeff_ready, 1);
        tick();
        return;
      end
    end
    at_neg();  // t+67
    chk("post_ready", bus.coeff_ready, 1);
    chk("post_busy", bus.busy, 0);
    chk("post_coeff_en", bus.fir_coeff_en, 0);
    tick();
    if (collide) begin  // t+68
      bus.sample_valid = 1'b0;
      at_neg();
      chk("next_sample_en", bus.fir_sample_en, 1);
      chk("next_sample", bus.fir_in, 32'h5678);
      tick();
    end
  endtask

  typedef struct {
    logic         sv;
    logic [W-1:0] sd;
    logic         e_sen;
    logic [W-1:0] e_fin;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit cr, sr;
    int rst_left;

    for (int k = 0; k < 12; k++) begin
      tbl[k].sv    = (k < 10);
      tbl[k].sd    = 32'hFFFF_FFF0 + W'(k);
      tbl[k].e_sen = (k >= 1 && k <= 10);
      tbl[k].e_fin = (k == 0) ? 32'h0 : 32'hFFFF_FFF0 + W'((k > 10) ? 9 : k - 1);
    end

    bus.coeff_data    = '0;
    bus.coeff_valid   = 1'b0;
    bus.coeff_restart = 1'b0;
    bus.sample_data   = '0;
    bus.sample_valid  = 1'b0;
    reset_n           = 1'b0;

    // reset held over three edges
    tick();
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("rst_fir_in", bus.fir_in, 0);
      chk("rst_cen", bus.fir_coeff_en, 0);
      chk("rst_sen", bus.fir_sample_en, 0);
      chk("rst_busy0", bus.busy, 0);
      chk("rst_cnt0", bus.coeff_cnt, 0);
      chk("rst_cready", bus.coeff_ready, 0);
      chk("rst_sready", bus.sample_ready, 0);
      tick();
    end
    reset_n = 1'b1;
    at_neg();
    chk("release_cready", bus.coeff_ready, 1);
    chk("release_sready", bus.sample_ready, 1);
    tick();

    // sample stream from the vector table
    for (int k = 0; k < 12; k++) begin
      bus.sample_valid = tbl[k].sv;
      bus.sample_data  = tbl[k].sd;
      at_neg();
      chk("tbl_sample_en", bus.fir_sample_en, tbl[k].e_sen);
      chk("tbl_fir_in", bus.fir_in, tbl[k].e_fin);
      chk("tbl_coeff_en", bus.fir_coeff_en, 0);
      tick();
    end

    load_set(32'h100, 1'b0, 1'b0);
    load_set(32'h200, 1'b1, 1'b0);

    // restart drops the partial set and the word riding with it
    for (int i = 0; i < 20; i++) begin
      bus.coeff_valid = 1'b1;
      bus.coeff_data  = 32'h700 + W'(i);
      tick();
    end
    bus.coeff_data    = 32'h714;
    bus.coeff_restart = 1'b1;
    at_neg();
    chk("cnt_before_restart", bus.coeff_cnt, 20);
    tick();
    bus.coeff_valid   = 1'b0;
    bus.coeff_restart = 1'b0;
    at_neg();
    chk("cnt_after_restart", bus.coeff_cnt, 0);
    tick();
    load_set(32'hA00, 1'b0, 1'b0);

    load_set(32'h300, 1'b0, 1'b1);
    load_set(32'h400, 1'b0, 1'b0);

    // random traffic, data held while stalled
    rst_left = 0;
    cr = 1'b1;
    sr = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (!(bus.coeff_valid && !cr)) begin
        bus.coeff_valid = ($urandom_range(0, 9) < 7);
        bus.coeff_data  = $urandom;
      end
      if (!(bus.sample_valid && !sr)) begin
        bus.sample_valid = ($urandom_range(0, 9) < 5);
        bus.sample_data  = $urandom;
      end
      bus.coeff_restart = ($urandom_range(0, 299) == 0);
      if (rst_left == 0 && $urandom_range(0, 799) == 0) rst_left = $urandom_range(1, 3);
      reset_n = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      at_neg();
      cr = bus.coeff_ready;
      sr = bus.sample_ready;
      tick();
    end

    bus.coeff_valid   = 1'b0;
    bus.sample_valid  = 1'b0;
    bus.coeff_restart = 1'b0;
    reset_n           = 1'b1;
    repeat (80) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
